// File: rtl/sparce_skip_engine_pkg.sv
// Shared types for the SPARCE skip engine: SASA table entry, skip condition
// and controller state, plus a saturating adder used by the statistics.
package sparce_pkg;

  // Storage widths of the packed entry; the engine zero-extends its
  // parameterised fields into these (DATA_W <= 64, RW <= 8, SKIP_W <= 16).
  localparam int SP_TAG_MAX_W  = 64;
  localparam int SP_RIDX_MAX_W = 8;
  localparam int SP_SKIP_MAX_W = 16;

  typedef enum logic {
    COND_AND = 1'b0,
    COND_OR  = 1'b1
  } cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SKIP = 1'b1
  } state_e;

  typedef struct packed {
    logic                     valid;
    logic [SP_TAG_MAX_W-1:0]  tag;
    logic [SP_RIDX_MAX_W-1:0] rs1;
    logic [SP_RIDX_MAX_W-1:0] rs2;
    logic [SP_SKIP_MAX_W-1:0] skip;
    cond_e                    cond;
  } sasa_entry_t;

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/sparce_skip_engine_if.sv
// Bus interface of the SPARCE skip engine (lookup, writeback, table write,
// redirect). Optional statistics outputs appear when SPARCE_STATS_EN is defined.
interface sparce_skip_engine_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
);
  localparam int RW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] pc;
  logic              lookup_en;
  logic              wb_en;
  logic [RW-1:0]     rd;
  logic [DATA_W-1:0] wb_data;
  logic              sasa_wen;
  logic [DATA_W-1:0] sasa_addr;
  logic [DATA_W-1:0] sasa_data;
  logic              redirect_ack;
  logic              skipping;
  logic [DATA_W-1:0] sparce_target;

`ifdef SPARCE_STATS_EN
  logic [31:0]       skip_count;
  logic [31:0]       insts_skipped;

  modport master (
    output pc, lookup_en, wb_en, rd, wb_data, sasa_wen, sasa_addr, sasa_data, redirect_ack,
    input  skipping, sparce_target, skip_count, insts_skipped
  );
  modport slave (
    input  pc, lookup_en, wb_en, rd, wb_data, sasa_wen, sasa_addr, sasa_data, redirect_ack,
    output skipping, sparce_target, skip_count, insts_skipped
  );
`else
  modport master (
    output pc, lookup_en, wb_en, rd, wb_data, sasa_wen, sasa_addr, sasa_data, redirect_ack,
    input  skipping, sparce_target
  );
  modport slave (
    input  pc, lookup_en, wb_en, rd, wb_data, sasa_wen, sasa_addr, sasa_data, redirect_ack,
    output skipping, sparce_target
  );
`endif

endinterface

// File: rtl/sparce_sasa_set_assoc.sv
// Set-associative SASA table: storage, replacement (tag match, first free,
// then per-set round-robin) and combinational hit lookup. The lookup reads the
// registered table, so a same-cycle write is not visible until the next cycle.
// SASA_SETS must be a power of two >= 2; SASA_WAYS a power of two >= 1.
module sparce_sasa_set_assoc
  import sparce_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RW        = 5,
  parameter int SKIP_W    = 5,
  parameter int SASA_SETS = 8,
  parameter int SASA_WAYS = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] lk_pc_i,
  output logic              lk_hit_o,
  output logic [RW-1:0]     lk_rs1_o,
  output logic [RW-1:0]     lk_rs2_o,
  output logic [SKIP_W-1:0] lk_skip_o,
  output cond_e             lk_cond_o
);

  localparam int SET_W    = $clog2(SASA_SETS);
  localparam int WAY_W    = (SASA_WAYS > 1) ? $clog2(SASA_WAYS) : 1;
  localparam int RS2_LSB  = RW;
  localparam int SKIP_LSB = 2 * RW;
  localparam int COND_BIT = 2 * RW + SKIP_W;

  sasa_entry_t        table_q [SASA_SETS][SASA_WAYS];
  logic [WAY_W-1:0]   rr_q    [SASA_SETS];

  logic [SET_W-1:0]     wr_set_s;
  logic [SASA_WAYS-1:0] wr_match_vec_s;
  logic [SASA_WAYS-1:0] wr_free_vec_s;
  logic [WAY_W-1:0]     wr_way_s;
  logic                 wr_use_rr_s;
  sasa_entry_t          wr_entry_s;

  logic [SET_W-1:0]     lk_set_s;
  logic [SASA_WAYS-1:0] lk_hit_vec_s;
  logic [WAY_W-1:0]     lk_way_s;
  sasa_entry_t          lk_entry_s;

  logic                 unused_lk_s;
  logic                 unused_wr_s;

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [WAY_W-1:0] lowest_way(input logic [SASA_WAYS-1:0] vec);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int w = SASA_WAYS - 1; w >= 0; w--) begin
      if (vec[w]) begin
        idx = WAY_W'(w);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Unpack the written word into a valid table entry.
  always_comb begin
    wr_entry_s       = '0;
    wr_entry_s.valid = 1'b1;
    wr_entry_s.tag   = SP_TAG_MAX_W'(wr_addr_i);
    wr_entry_s.rs1   = SP_RIDX_MAX_W'(wr_data_i[RW-1:0]);
    wr_entry_s.rs2   = SP_RIDX_MAX_W'(wr_data_i[RS2_LSB +: RW]);
    wr_entry_s.skip  = SP_SKIP_MAX_W'(wr_data_i[SKIP_LSB +: SKIP_W]);
    wr_entry_s.cond  = cond_e'(wr_data_i[COND_BIT]);
  end

  // Pick the victim way: matching tag, else first free, else round-robin.
  always_comb begin
    wr_set_s = wr_addr_i[2 +: SET_W];
    for (int w = 0; w < SASA_WAYS; w++) begin
      wr_match_vec_s[w] = table_q[wr_set_s][w].valid &&
                          (table_q[wr_set_s][w].tag == SP_TAG_MAX_W'(wr_addr_i));
      wr_free_vec_s[w]  = !table_q[wr_set_s][w].valid;
    end
    if (|wr_match_vec_s) begin
      wr_way_s = lowest_way(wr_match_vec_s);
    end else if (|wr_free_vec_s) begin
      wr_way_s = lowest_way(wr_free_vec_s);
    end else begin
      wr_way_s = rr_q[wr_set_s];
    end
    wr_use_rr_s = !(|wr_match_vec_s) && !(|wr_free_vec_s);
  end

  // Table and round-robin pointer storage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SASA_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < SASA_WAYS; w++) begin
          table_q[s][w] <= '0;
        end
      end
    end else if (wr_en_i) begin
      table_q[wr_set_s][wr_way_s] <= wr_entry_s;
      if (wr_use_rr_s) begin
        rr_q[wr_set_s] <= (rr_q[wr_set_s] == WAY_W'(SASA_WAYS - 1)) ?
                          '0 : rr_q[wr_set_s] + WAY_W'(1);
      end
    end
  end

  // Hit lookup on the pre-write table; lowest matching way wins.
  always_comb begin
    lk_set_s = lk_pc_i[2 +: SET_W];
    for (int w = 0; w < SASA_WAYS; w++) begin
      lk_hit_vec_s[w] = table_q[lk_set_s][w].valid &&
                        (table_q[lk_set_s][w].tag == SP_TAG_MAX_W'(lk_pc_i));
    end
    lk_way_s   = lowest_way(lk_hit_vec_s);
    lk_entry_s = table_q[lk_set_s][lk_way_s];
  end

  assign lk_hit_o  = |lk_hit_vec_s;
  assign lk_rs1_o  = lk_entry_s.rs1[RW-1:0];
  assign lk_rs2_o  = lk_entry_s.rs2[RW-1:0];
  assign lk_skip_o = lk_entry_s.skip[SKIP_W-1:0];
  assign lk_cond_o = lk_entry_s.cond;

  // Padding bits of the entry and the unused top of the data word.
  assign unused_lk_s = ^lk_entry_s;
  assign unused_wr_s = ^wr_data_i;

endmodule

// File: rtl/sparce_skip_engine.sv
// SPARCE skip engine top: sparsity file, skip-condition evaluation with
// writeback bypass, IDLE/SKIP redirect controller and target computation.
// Define SPARCE_STATS_EN to add the saturating skip_count / insts_skipped outputs.
module sparce_skip_engine
  import sparce_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int SASA_SETS = 8,
  parameter int SASA_WAYS = 2,
  parameter int SKIP_W    = 5
) (
  input logic                 CLK,
  input logic                 nRST,
  sparce_skip_engine_if.slave bus
);

  localparam int RW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] sp_q, sp_d;
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   target_q, target_d;

  logic                lk_hit_s;
  logic [RW-1:0]       lk_rs1_s, lk_rs2_s;
  logic [SKIP_W-1:0]   lk_skip_s;
  cond_e               lk_cond_s;

  logic                wb_zero_s;
  logic                sp_rs1_s, sp_rs2_s;
  logic                cond_true_s;
  logic                go_skip_s;
  logic [DATA_W-1:0]   target_calc_s;

  // Sparsity of a source register: x0 is always zero, a same-cycle writeback wins.
  function automatic logic sp_read(input logic [RW-1:0]       r,
                                   input logic [NUM_REGS-1:0] sp,
                                   input logic                byp_en,
                                   input logic [RW-1:0]       byp_rd,
                                   input logic                byp_zero);
    if (r == '0) begin
      return 1'b1;
    end else if (byp_en && (byp_rd == r)) begin
      return byp_zero;
    end else begin
      return sp[r];
    end
  endfunction

  sparce_sasa_set_assoc #(
    .DATA_W    (DATA_W),
    .RW        (RW),
    .SKIP_W    (SKIP_W),
    .SASA_SETS (SASA_SETS),
    .SASA_WAYS (SASA_WAYS)
  ) u_sasa (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .wr_en_i   (bus.sasa_wen),
    .wr_addr_i (bus.sasa_addr),
    .wr_data_i (bus.sasa_data),
    .lk_pc_i   (bus.pc),
    .lk_hit_o  (lk_hit_s),
    .lk_rs1_o  (lk_rs1_s),
    .lk_rs2_o  (lk_rs2_s),
    .lk_skip_o (lk_skip_s),
    .lk_cond_o (lk_cond_s)
  );

  assign wb_zero_s = (bus.wb_data == '0);

  // Sparsity file next state: writeback records whether the value is zero.
  always_comb begin
    sp_d = sp_q;
    if (bus.wb_en && (bus.rd != '0)) begin
      sp_d[bus.rd] = wb_zero_s;
    end else begin
      sp_d = sp_q;
    end
    sp_d[0] = 1'b1;
  end

  // Sparsity file register, all registers considered zero after reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sp_q <= '1;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Evaluate the entry's skip condition and decide whether to redirect.
  always_comb begin
    sp_rs1_s = sp_read(lk_rs1_s, sp_q, bus.wb_en, bus.rd, wb_zero_s);
    sp_rs2_s = sp_read(lk_rs2_s, sp_q, bus.wb_en, bus.rd, wb_zero_s);
    if (lk_cond_s == COND_OR) begin
      cond_true_s = sp_rs1_s || sp_rs2_s;
    end else begin
      cond_true_s = sp_rs1_s && sp_rs2_s;
    end
    go_skip_s = bus.lookup_en && (state_q == ST_IDLE) && lk_hit_s && cond_true_s;
  end

  // Redirect target: the instruction after the skipped block, wrapping at 2^DATA_W.
  assign target_calc_s = bus.pc + ((DATA_W'(lk_skip_s) + DATA_W'(1)) << 2'd2);

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next state: enter SKIP on a taken lookup, leave on acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_skip_s) begin
          state_d = ST_SKIP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (bus.redirect_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SKIP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller outputs: capture the target only when entering SKIP.
  always_comb begin
    target_d = target_q;
    if (go_skip_s) begin
      target_d = target_calc_s;
    end else begin
      target_d = target_q;
    end
  end

  // Registered redirect target.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      target_q <= '0;
    end else begin
      target_q <= target_d;
    end
  end

  assign bus.skipping      = (state_q == ST_SKIP);
  assign bus.sparce_target = target_q;

`ifdef SPARCE_STATS_EN
  logic [31:0] skip_count_q, skip_count_d;
  logic [31:0] insts_skipped_q, insts_skipped_d;

  // Statistics next state: count redirects and the instructions they bypass.
  always_comb begin
    if (go_skip_s) begin
      skip_count_d    = sat_add32(skip_count_q, 32'd1);
      insts_skipped_d = sat_add32(insts_skipped_q, 32'(lk_skip_s) + 32'd1);
    end else begin
      skip_count_d    = skip_count_q;
      insts_skipped_d = insts_skipped_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      skip_count_q    <= 32'd0;
      insts_skipped_q <= 32'd0;
    end else begin
      skip_count_q    <= skip_count_d;
      insts_skipped_q <= insts_skipped_d;
    end
  end

  assign bus.skip_count    = skip_count_q;
  assign bus.insts_skipped = insts_skipped_q;
`endif

endmodule

// File: tb/tb_sparce_skip_engine.sv
// Directed bench for sparce_skip_engine with an expectation queue; statistics
// checks are compiled in when SPARCE_STATS_EN is defined.
module tb_sparce_skip_engine;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  sparce_skip_engine_if #(.DATA_W(32), .NUM_REGS(32)) bus ();

  sparce_skip_engine #(
    .DATA_W    (32),
    .NUM_REGS  (32),
    .SASA_SETS (8),
    .SASA_WAYS (2),
    .SKIP_W    (5)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic        skip;
    logic [31:0] tgt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [31:0] mk(input int rs1, input int rs2, input int skip, input logic cond);
    logic [31:0] d;
    d        = 32'd0;
    d[4:0]   = 5'(rs1);
    d[9:5]   = 5'(rs2);
    d[14:10] = 5'(skip);
    d[15]    = cond;
    return d;
  endfunction

  task automatic clr();
    bus.pc           = 32'd0;
    bus.lookup_en    = 1'b0;
    bus.wb_en        = 1'b0;
    bus.rd           = 5'd0;
    bus.wb_data      = 32'd0;
    bus.sasa_wen     = 1'b0;
    bus.sasa_addr    = 32'd0;
    bus.sasa_data    = 32'd0;
    bus.redirect_ack = 1'b0;
  endtask

  task automatic wr(input logic [31:0] tag, input logic [31:0] data);
    bus.sasa_wen  = 1'b1;
    bus.sasa_addr = tag;
    bus.sasa_data = data;
  endtask

  task automatic lk(input logic [31:0] pc);
    bus.lookup_en = 1'b1;
    bus.pc        = pc;
  endtask

  task automatic wb(input int r, input logic [31:0] v);
    bus.wb_en   = 1'b1;
    bus.rd      = 5'(r);
    bus.wb_data = v;
  endtask

  // Queue the outputs expected after the next edge, clock, then compare.
  task automatic step(input logic es, input logic [31:0] et, input string nm);
    exp_t e;
    exp_t got;
    e.skip = es;
    e.tgt  = et;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    got = exp_q.pop_front();
    vectors++;
    assert (bus.skipping === got.skip) else begin
      miscompares++;
      $error("FAIL %s skipping: observed %0b expected %0b", got.name, bus.skipping, got.skip);
    end
    vectors++;
    assert (bus.sparce_target === got.tgt) else begin
      miscompares++;
      $error("FAIL %s target: observed %h expected %h", got.name, bus.sparce_target, got.tgt);
    end
    clr();
  endtask

  task automatic ack(input logic [31:0] et, input string nm);
    bus.redirect_ack = 1'b1;
    step(1'b0, et, nm);
  endtask

`ifdef SPARCE_STATS_EN
  task automatic chk32(input logic [31:0] obs, input logic [31:0] expv, input string nm);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", nm, obs, expv);
    end
  endtask
`endif

  initial begin
    clr();
    nRST = 1'b0;
    step(1'b0, 32'h0, "reset0");
    step(1'b0, 32'h0, "reset1");
    nRST = 1'b1;

    // Sparsity file starts all-zero: fresh entry skips without any writeback.
    wr(32'h100, mk(5, 5, 3, 1'b0));     step(1'b0, 32'h0,   "wr100");
    lk(32'h100);                        step(1'b1, 32'h110, "rst_sparse");
    ack(32'h110, "ack_a");

    // Basic skip after wb x5=0.
    wb(5, 32'd0);                       step(1'b0, 32'h110, "wb5_0");
    lk(32'h100);                        step(1'b1, 32'h110, "basic_skip");
    ack(32'h110, "ack_b");

    // Bypass: same-cycle writeback decides the condition.
    lk(32'h100); wb(5, 32'd7);          step(1'b0, 32'h110, "bypass_nz");
    lk(32'h100);                        step(1'b0, 32'h110, "x5_nonzero");
    lk(32'h100); wb(5, 32'd0);          step(1'b1, 32'h110, "bypass_z");
    ack(32'h110, "ack_c");

    // OR condition on distinct registers.
    wr(32'h104, mk(5, 6, 0, 1'b1));     step(1'b0, 32'h110, "wr104");
    wb(6, 32'd9);                       step(1'b0, 32'h110, "wb6_9");
    wb(5, 32'd1);                       step(1'b0, 32'h110, "wb5_1");
    lk(32'h104);                        step(1'b0, 32'h110, "or_false");
    wb(6, 32'd0);                       step(1'b0, 32'h110, "wb6_0");
    lk(32'h104);                        step(1'b1, 32'h108, "or_true");
    ack(32'h108, "ack_d");

    // Replacement in set 0 (two ways).
    wr(32'h200, mk(0, 0, 1, 1'b0));     step(1'b0, 32'h108, "wr200");
    wr(32'h300, mk(0, 0, 2, 1'b0));     step(1'b0, 32'h108, "wr300");
    lk(32'h100);                        step(1'b0, 32'h108, "evicted100");
    lk(32'h200);                        step(1'b1, 32'h208, "hit200");
    ack(32'h208, "ack_e1");
    lk(32'h300);                        step(1'b1, 32'h30C, "hit300");
    ack(32'h30C, "ack_e2");
    wr(32'h200, mk(0, 0, 4, 1'b0));     step(1'b0, 32'h30C, "rewr200");
    lk(32'h200);                        step(1'b1, 32'h214, "inplace200");
    ack(32'h214, "ack_e3");
    lk(32'h300);                        step(1'b1, 32'h30C, "kept300");
    ack(32'h30C, "ack_e4");
    wr(32'h400, mk(0, 0, 6, 1'b0));     step(1'b0, 32'h30C, "wr400_rr");
    lk(32'h200);                        step(1'b0, 32'h30C, "evicted200");
    lk(32'h400);                        step(1'b1, 32'h41C, "hit400");
    ack(32'h41C, "ack_e5");
    lk(32'h300);                        step(1'b1, 32'h30C, "still300");
    ack(32'h30C, "ack_e6");

    // Same-cycle write and lookup sees the old table.
    wr(32'h500, mk(0, 0, 0, 1'b0)); lk(32'h500); step(1'b0, 32'h30C, "prewrite");
    lk(32'h500);                        step(1'b1, 32'h504, "postwrite");

    // Held in SKIP: lookups ignored, table write and writeback still taken.
    lk(32'h400); wr(32'h600, mk(0, 0, 7, 1'b0)); step(1'b1, 32'h504, "hold1");
    lk(32'h400); wb(9, 32'd3);          step(1'b1, 32'h504, "hold2");
    lk(32'h500);                        step(1'b1, 32'h504, "hold3");
    lk(32'h400);                        step(1'b1, 32'h504, "hold4");
    ack(32'h504, "ack_g");
    lk(32'h600);                        step(1'b1, 32'h620, "wr_in_skip");
    ack(32'h620, "ack_g2");
    wr(32'h108, mk(9, 9, 0, 1'b0));     step(1'b0, 32'h620, "wr108");
    lk(32'h108);                        step(1'b0, 32'h620, "wb_in_skip");

    // Acknowledge while IDLE has no effect.
    lk(32'h500); bus.redirect_ack = 1'b1; step(1'b1, 32'h504, "ack_idle_hit");
    ack(32'h504, "ack_h");
    ack(32'h504, "ack_idle_only");

    // Target wraps; x0 stays zero after writing it.
    wr(32'hFFFF_FFFC, mk(0, 0, 0, 1'b0)); step(1'b0, 32'h504, "wr_top");
    wb(0, 32'd5);                       step(1'b0, 32'h504, "wb_x0");
    lk(32'hFFFF_FFFC);                  step(1'b1, 32'h0,   "wrap");
    ack(32'h0, "ack_i");

    // Reset while skipping.
    lk(32'h500);                        step(1'b1, 32'h504, "pre_rst_skip");
    nRST = 1'b0;                        step(1'b0, 32'h0,   "rst_in_skip");
    nRST = 1'b1;
    lk(32'h500);                        step(1'b0, 32'h0,   "table_cleared");

`ifdef SPARCE_STATS_EN
    chk32(bus.skip_count, 32'd0, "cnt_rst");
    chk32(bus.insts_skipped, 32'd0, "insts_rst");
    wr(32'h100, mk(0, 0, 3, 1'b0));     step(1'b0, 32'h0,   "s_wr100");
    wr(32'h104, mk(0, 0, 1, 1'b0));     step(1'b0, 32'h0,   "s_wr104");
    lk(32'h100);                        step(1'b1, 32'h110, "s_skip1");
    ack(32'h110, "s_ack1");
    lk(32'h104);                        step(1'b1, 32'h10C, "s_skip2");
    ack(32'h10C, "s_ack2");
    chk32(bus.skip_count, 32'd2, "cnt_two");
    chk32(bus.insts_skipped, 32'd6, "insts_six");
    lk(32'h100);                        step(1'b1, 32'h110, "s_skip3");
    nRST = 1'b0;                        step(1'b0, 32'h0,   "s_rst");
    nRST = 1'b1;
    chk32(bus.skip_count, 32'd0, "cnt_clr");
    chk32(bus.insts_skipped, 32'd0, "insts_clr");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sparce_skip_engine.md
SPARCE_SKIP_ENGINE -- requirements
Module: sparce_skip_engine

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, width of pc, wb_data, sasa_addr, sasa_data and sparce_target.
REQ-002 The block SHALL expose parameter NUM_REGS, default 32, number of tracked architectural registers; index width RW = clog2(NUM_REGS).
REQ-003 The block SHALL expose parameter SASA_SETS, default 8, power of two; and SASA_WAYS, default 2, power of two, at least 1.
REQ-004 The block SHALL expose parameter SKIP_W, default 5, width of the skip-count field.
REQ-005 Ports SHALL be:
- CLK  in  1  single clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- pc  in  DATA_W  fetch PC under lookup
- lookup_en  in  1  lookup request this cycle
- wb_en  in  1  register writeback valid
- rd  in  RW  writeback destination
- wb_data  in  DATA_W  writeback value
- sasa_wen  in  1  table write strobe
- sasa_addr  in  DATA_W  PC tag of the entry
- sasa_data  in  DATA_W  packed entry: [RW-1:0] rs1, [2RW-1:RW] rs2, [2RW+SKIP_W-1:2RW] skip count, [2RW+SKIP_W] cond (0=AND, 1=OR)
- redirect_ack  in  1  pipeline accepted the redirect
- skipping  out  1  skip redirect pending
- sparce_target  out  DATA_W  redirect PC

Function
REQ-006 Sparsity file: one bit per register; on wb_en with rd!=0, bit[rd] SHALL become (wb_data==0) at the next edge; bit 0 SHALL read as 1 always.
REQ-007 Set index SHALL be pc[2 +: clog2(SASA_SETS)]; tag SHALL be the full DATA_W PC, compared exactly.
REQ-008 Write: on sasa_wen, a valid way with equal tag in the set SHALL be overwritten in place; otherwise the first invalid way; otherwise the way named by the set's round-robin pointer, which then increments modulo SASA_WAYS.
REQ-009 Lookup hit SHALL require lookup_en, state IDLE, a valid way with tag==pc; with multiple matches the lowest way SHALL win.
REQ-010 Condition SHALL be sp[rs1]&&sp[rs2] (cond=0) or sp[rs1]||sp[rs2] (cond=1), using the same-cycle wb value when wb_en and rd equals rs1/rs2 (bypass).
REQ-011 FSM states IDLE and SKIP; IDLE->SKIP on hit with true condition; SKIP->IDLE on redirect_ack; all other cases hold state.
REQ-012 On IDLE->SKIP, sparce_target SHALL register pc + ((skip+1)<<2), truncated modulo 2^DATA_W; skipping SHALL be 1 exactly while in SKIP (one-cycle latency from lookup).
REQ-013 In SKIP, lookups SHALL be ignored; sparce_target SHALL hold; table writes and writebacks SHALL still be accepted.
REQ-014 Simultaneous sasa_wen and lookup on the same set SHALL use pre-write table contents for the lookup.
REQ-015 redirect_ack in IDLE SHALL be ignored.

Reset
REQ-016 When nRST=0 at an edge: all valid bits 0, round-robin pointers 0, all sparsity bits 1, state IDLE, skipping 0, sparce_target 0, statistics counters 0.
REQ-017 Reset asserted in SKIP SHALL drop skipping on the same edge with no ack required.

Configuration
REQ-018 Macro SPARCE_STATS_EN SHALL, when defined, add outputs skip_count (32 bit, +1 per IDLE->SKIP) and insts_skipped (32 bit, +skip+1 per IDLE->SKIP), both saturating at all-ones.
REQ-019 Without SPARCE_STATS_EN those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-020 Package sparce_pkg SHALL hold the SASA entry struct (valid, tag, rs1, rs2, skip, cond), the cond enum and the FSM state enum.
REQ-021 Sub-module sparce_sasa_set_assoc SHALL implement table storage, replacement and hit lookup; FSM, sparsity file and target math stay at top level.

Verification
REQ-022 Write tag 0x100 {rs1=5,rs2=5,skip=3,AND}; wb x5=0; lookup pc 0x100 -> next cycle skipping=1, sparce_target=0x110.
REQ-023 Same entry, same cycle as lookup wb x5=7 -> skipping stays 0 (bypass).
REQ-024 SASA_WAYS=2: write three tags mapping to set 0 -> third replaces way 0; lookup of first tag misses, second and third hit.
REQ-025 Enter SKIP, hold redirect_ack=0 for 4 cycles with new hitting lookups -> target unchanged; ack -> IDLE next cycle.
REQ-026 Entry at tag 0xFFFFFFFC skip=0 -> sparce_target=0x00000000; wb rd=0 value 5 then lookup using rs1=0 -> still sparse.
REQ-027 With SPARCE_STATS_EN, two skips with skip=3 and 1 -> skip_count=2, insts_skipped=6; nRST=0 during SKIP -> skipping=0 and counters 0 next cycle.
